core_memory: RTL

- Word-addressed main-memory responder: the memory end of the CPU memory interface (17-bit word address, 32-bit big-endian word, bit 0 = MSB).
- Accepts one read or write request at a time, spends a programmable number of wait cycles, then returns a single-cycle acknowledge with read data.
- Reports nonexistent-memory (NXM) for addresses beyond the populated depth, so the CPU microcode can trap.

---
 rtl/core_memory.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/core_memory.sv
// -----------------------------------------------------------------------------
// core_memory
//
// Word-addressed main-memory responder sitting at the memory end of the CPU
// memory interface. One request is accepted at a time. The request is held for
// a programmable number of wait cycles, and then a single-cycle acknowledge is
// returned with the read data. Addresses at or beyond the populated depth
// report nonexistent memory (NXM), so microcode can trap on them.
//
// Bus numbering is big-endian: bit 0 is the MSB of the data word, and the
// address occupies bits [15:31].
//
// Parameters
//   DEPTH     populated words; legal addresses are 0..DEPTH-1 (1..131072)
//   LATENCY   clock edges from request acceptance to acknowledge (1..15)
//   INIT_FILE hex image loaded into the array at time 0 when non-empty
//
// Ports
//   clock      system clock, rising-edge active
//   reset      asynchronous, active-high; aborts any access in flight
//   mem_req    request strobe, sampled only while mem_busy is low
//   mem_we     1 = write, 0 = read (captured with mem_req)
//   mem_addr   17-bit word address (captured with mem_req)
//   mem_wdata  write data (captured with mem_req)
//   mem_bmask  byte write enables; bit 0 -> data[0:7], bit 3 -> data[24:31]
//   mem_rdata  read data, valid with mem_ack and held until the next read
//   mem_ack    one-cycle completion pulse
//   mem_busy   request in progress; new requests are ignored while high
//   mem_nxm    valid with mem_ack: the address was >= DEPTH
// -----------------------------------------------------------------------------
module core_memory #(
    parameter int    DEPTH     = 16384,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [15:31]  mem_addr,
    input  logic [0:31]   mem_wdata,
    input  logic [0:3]    mem_bmask,
    output logic [0:31]   mem_rdata,
    output logic          mem_ack,
    output logic          mem_busy,
    output logic          mem_nxm
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    state_t       state;
    logic [3:0]   wait_cnt;

    // Captured request. Internally the vectors are descending, so index 0 is
    // the LSB. Positional assignment maps mem_wdata[0] onto wdata_p0[31] and
    // mem_bmask[0] onto bmask_p0[3]. As a result, bmask_p0[b] covers
    // wdata_p0[8*b +: 8].
    logic         we_p0;
    logic [16:0]  addr_p0;
    logic [31:0]  wdata_p0;
    logic [3:0]   bmask_p0;

    logic [31:0]  rdata_q;
    logic [31:0]  mem_array [0:DEPTH-1];

    logic          in_range;
    logic [AW-1:0] index;
    logic          perform;

    // Replace only the enabled bytes of a stored word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = mask[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

    // Compare is done on 18 bits, so DEPTH = 131072 still fits and no address wraps.
    assign in_range  = ({1'b0, addr_p0} < 18'(DEPTH));
    assign index     = addr_p0[AW-1:0];
    assign perform   = (state == WAIT) && (wait_cnt == 4'd0);
    assign mem_rdata = rdata_q;

    // ---- request capture (p0): data only, no reset needed ----
    always_ff @(posedge clock) begin
        if (state == IDLE && mem_req) begin
            we_p0    <= mem_we;
            addr_p0  <= mem_addr;
            wdata_p0 <= mem_wdata;
            bmask_p0 <= mem_bmask;
        end
    end

    // ---- control FSM and response registers ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            mem_ack  <= 1'b0;
            mem_busy <= 1'b0;
            mem_nxm  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        state    <= WAIT;
                        wait_cnt <= 4'(LATENCY - 1);
                        mem_busy <= 1'b1;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= ACK;
                        mem_ack <= 1'b1;
                        mem_nxm <= ~in_range;
                        // A write leaves the last read result untouched.
                        if (!we_p0) begin
                            rdata_q <= in_range ? mem_array[index] : 32'd0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    mem_ack  <= 1'b0;
                    mem_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    mem_ack  <= 1'b0;
                    mem_busy <= 1'b0;
                end
            endcase
        end
    end

    // ---- array write: commits only on the edge that enters ACK ----
    // A reset during WAIT forces the state back to IDLE, so perform stays low
    // and the pending write is dropped.
    always_ff @(posedge clock) begin
        if (perform && we_p0 && in_range) begin
            mem_array[index] <= merge_bytes(mem_array[index], wdata_p0, bmask_p0);
        end
    end

endmodule
